pi_txn_queue: RTL and testbench
===============================

# pi_txn_queue

Posted-transaction queue between the Pi register-write decoder and the 68K bus-cycle engine, in the `c200m` domain. It assembles data and address register writes into complete bus requests and holds up to DEPTH of them. It hands requests to the bus engine one at a time over a req/ack/done handshake and captures read data for the Pi. With it, the Pi can post several writes back-to-back without polling for each 68K cycle to finish.

## Interface
Parameters:
- `DEPTH`, 4, queue entries; power of two, 2..16
- `CW`, $clog2(DEPTH)+1, occupancy counter width

Ports:
- `c200m` in 1: the only clock, the Pi-side 200 MHz clock
- `reset` in 1: synchronous, active-high
- `wr_stb` in 1: one-cycle pulse; the Pi register write is already synchronized and edge-detected
- `wr_reg` in 2: register select; 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS
- `wr_data` in 16: register write data
- `op_req` out 1: head entry offered to the bus engine
- `op_rw` out 1: 1=read, 0=write
- `op_uds_n` out 1: upper data strobe for the head entry
- `op_lds_n` out 1: lower data strobe for the head entry
- `op_addr` out 24: 68K byte address; bit 0 is carried but not driven on the bus
- `op_wdata` out 16: write data
- `op_ack` in 1: one-cycle pulse; the engine has latched the head (its S1)
- `op_done` in 1: one-cycle pulse; the bus cycle has completed (its S7)
- `op_rdata` in 16: read data, valid in the `op_done` cycle
- `rdata` out 16: last captured read data
- `txn_in_progress` out 1: queue non-empty or a cycle is in flight
- `full` out 1: occupancy == DEPTH
- `overflow` out 1: sticky flag; a push was dropped

## Operation
Staging registers (not queue storage):
- `wd[15:0]`: loaded on DATA writes.
- `al[15:0]`: loaded on ADDR_LO writes.

Register-write actions, each on `wr_stb`:
- DATA: `wd` <= `wr_data`.
- ADDR_LO: `al` <= `wr_data`.
- ADDR_HI: push one entry, provided the queue is not full:
  - addr = {`wr_data[7:0]`, `al`}
  - rw = `wr_data[9]`
  - wdata = `wd`
  - if `wr_data[8]` = 1 (byte access): uds_n = `al[0]`, lds_n = !`al[0]`
  - otherwise (word access): uds_n = 0, lds_n = 0
- STATUS: if `wr_data[15]` = 1, clear `overflow`. No other effect in this block.

Queue storage:
- Circular buffer with `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy counter `count` is CW bits wide.

State machine on `busy`:
- IDLE (`busy`=0):
  - `op_req` = (`count` != 0).
  - `op_*` outputs show the head entry combinationally from `rd_ptr`.
- On `op_ack` while `op_req`=1, go to BUSY:
  - latch the head's rw into `inflight_rw`;
  - `rd_ptr` += 1, `count` -= 1;
  - `op_req` is forced low.
- BUSY (`busy`=1): `op_req` = 0. The `op_*` outputs hold the latched in-flight entry, so the engine can sample them during the cycle.
- On `op_done` while BUSY, return to IDLE:
  - if `inflight_rw`=1, `rdata` <= `op_rdata`.

Status outputs:
- `txn_in_progress` = (`count` != 0) | `busy`, registered.
- `full` = (`count` == DEPTH).

Boundary cases:
- Push when full and no pop in the same cycle: the entry is dropped, `overflow` <= 1, and pointers are unchanged.
- Push and pop in the same cycle: both take effect and `count` is unchanged. This holds even when full, because the pop frees a slot first.
- Empty queue: `op_req` = 0 and the `op_*` outputs hold their last values.
- `op_ack` while `op_req`=0: ignored. `op_done` while not BUSY: ignored.
- `op_ack` and `op_done` in the same cycle: `op_done` is processed first (when BUSY), then `op_ack` is ignored, since `op_req` was 0.
- Reads are queued in order, like writes. The Pi must wait for `txn_in_progress`=0 before reading `rdata`.

Reset (synchronous):
- Pointers, `count`, `busy`, `inflight_rw`, `wd`, `al` and `overflow` go to 0.
- Output values: `op_req`=0, `op_rw`=1, `op_uds_n`=1, `op_lds_n`=1, `op_addr`=0, `op_wdata`=0, `rdata`=0, `txn_in_progress`=0, `full`=0, `overflow`=0.
- A reset during BUSY abandons the in-flight cycle. Any later `op_done` is ignored.

## Timing
- ADDR_HI push in cycle N into an empty, idle queue: `op_req`=1 in cycle N+1, with fields valid in the same cycle.
- `op_ack` in cycle M: `op_req`=0 in cycle M+1.
- `op_done` in cycle K:
  - `rdata` is updated and `busy`=0 in cycle K+1;
  - `op_req` can reassert in cycle K+1 if the queue is non-empty.
- `txn_in_progress` rises in cycle N+1 after the first push and falls in cycle K+1 after the last `op_done`.
- `full` and `overflow` update one cycle after the causing edge.
- Minimum turnaround is one idle cycle between `op_done` and the next `op_ack`.

## Test plan
- Word write: DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0056 -> `op_req`=1 with `op_addr`=0x561234, `op_rw`=0, `op_uds_n`=0, `op_lds_n`=0, `op_wdata`=0xBEEF. After ack then done, `txn_in_progress`=0.
- Byte read at odd address: ADDR_LO=0x0001, ADDR_HI=0x0300 (byte, read) -> `op_uds_n`=1, `op_lds_n`=0, `op_rw`=1. `op_done` with `op_rdata`=0x00A5 -> `rdata`=0x00A5 in the next cycle.
- Fill: 4 pushes with no ack -> `full`=1 and `count`=4. A fifth push -> `overflow`=1 and the entries are unchanged. A STATUS write of 0x8000 -> `overflow`=0.
- Push on the same cycle as `op_ack` with the queue full -> `count` stays 4, `full` stays 1, `overflow` stays 0. The pushed entry drains last (FIFO order checked on `op_addr`).
- Reset asserted while BUSY -> next cycle all outputs are at reset values; a later `op_done` does not change `rdata`.
- `op_done` pulse while idle and `op_ack` pulse with the queue empty -> no state change, `op_req` stays 0.

Source files
------------

// File: rtl/pi_txn_queue.sv
// Posted-transaction queue: turns Pi register writes into 68K bus requests and
// offers them one at a time to the bus-cycle engine over req/ack/done.
module pi_txn_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic        c200m,
  input  logic        reset,
  input  logic        wr_stb,
  input  logic [1:0]  wr_reg,
  input  logic [15:0] wr_data,
  output logic        op_req,
  output logic        op_rw,
  output logic        op_uds_n,
  output logic        op_lds_n,
  output logic [23:0] op_addr,
  output logic [15:0] op_wdata,
  input  logic        op_ack,
  input  logic        op_done,
  input  logic [15:0] op_rdata,
  output logic [15:0] rdata,
  output logic        txn_in_progress,
  output logic        full,
  output logic        overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [23:0] addr;
    logic [15:0] wdata;
  } entry_t;

  localparam entry_t ENTRY_RST = '{rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1,
                                   addr: 24'h0, wdata: 16'h0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_rw_q, inflight_rw_d;
  logic [15:0]   wd_q, wd_d;
  logic [15:0]   al_q, al_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          txn_q, txn_d;
  logic          full_q, full_d;
  entry_t        out_q, out_d;
  entry_t        mem_q [DEPTH];

  entry_t head;
  entry_t new_entry;
  logic   is_push;
  logic   push_ok;
  logic   pop;
  logic   q_empty;
  logic   q_full;
  logic   req_c;

  assign head    = mem_q[rd_ptr_q];
  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CW'(DEPTH));
  assign req_c   = (state_q == ST_IDLE) && !q_empty;
  assign is_push = wr_stb && (wr_reg == REG_ADDR_HI);
  assign pop     = req_c && op_ack;
  // A simultaneous pop frees the slot the push needs, so full only blocks a lone push.
  assign push_ok = is_push && (!q_full || pop);

  // Entry assembled from the staging registers and the ADDR_HI write.
  always_comb begin
    new_entry       = ENTRY_RST;
    new_entry.rw    = wr_data[9];
    new_entry.addr  = {wr_data[7:0], al_q};
    new_entry.wdata = wd_q;
    if (wr_data[8]) begin
      new_entry.uds_n = al_q[0];
      new_entry.lds_n = !al_q[0];
    end else begin
      new_entry.uds_n = 1'b0;
      new_entry.lds_n = 1'b0;
    end
  end

  // Next-state logic: staging, queue bookkeeping and the idle/busy handshake.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_rw_d = inflight_rw_q;
    wd_d          = wd_q;
    al_d          = al_q;
    overflow_d    = overflow_q;
    rdata_d       = rdata_q;
    out_d         = out_q;

    if (wr_stb) begin
      case (wr_reg)
        REG_DATA:    wd_d = wr_data;
        REG_ADDR_LO: al_d = wr_data;
        REG_STATUS:  if (wr_data[15]) overflow_d = 1'b0;
        default:     ;
      endcase
    end

    if (is_push && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Track the head so the outputs keep their last values once the queue drains.
        if (!q_empty) begin
          out_d = head;
        end
        if (pop) begin
          state_d       = ST_BUSY;
          inflight_rw_d = head.rw;
          rd_ptr_d      = rd_ptr_q + PW'(1);
        end
      end
      ST_BUSY: begin
        if (op_done) begin
          state_d = ST_IDLE;
          if (inflight_rw_q) begin
            rdata_d = op_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign txn_d  = (count_d != '0) || (state_d == ST_BUSY);
  assign full_d = (count_d == CW'(DEPTH));

  always_ff @(posedge c200m) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_rw_q <= 1'b0;
      wd_q          <= 16'h0;
      al_q          <= 16'h0;
      overflow_q    <= 1'b0;
      rdata_q       <= 16'h0;
      txn_q         <= 1'b0;
      full_q        <= 1'b0;
      out_q         <= ENTRY_RST;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_rw_q <= inflight_rw_d;
      wd_q          <= wd_d;
      al_q          <= al_d;
      overflow_q    <= overflow_d;
      rdata_q       <= rdata_d;
      txn_q         <= txn_d;
      full_q        <= full_d;
      out_q         <= out_d;
    end
  end

  // Queue storage needs no reset; occupancy guards every read.
  always_ff @(posedge c200m) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Idle with work pending shows the live head; otherwise the held entry.
  entry_t op_entry;
  assign op_entry = req_c ? head : out_q;

  assign op_req          = req_c;
  assign op_rw           = op_entry.rw;
  assign op_uds_n        = op_entry.uds_n;
  assign op_lds_n        = op_entry.lds_n;
  assign op_addr         = op_entry.addr;
  assign op_wdata        = op_entry.wdata;
  assign rdata           = rdata_q;
  assign txn_in_progress = txn_q;
  assign full            = full_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_pi_txn_queue.sv
// Directed self-checking bench for pi_txn_queue: one task per scenario.
module tb_pi_txn_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_stb = 1'b0;
  logic [1:0]  wr_reg = 2'd0;
  logic [15:0] wr_data = 16'h0;
  logic        op_ack = 1'b0;
  logic        op_done = 1'b0;
  logic [15:0] op_rdata = 16'h0;
  logic        op_req, op_rw, op_uds_n, op_lds_n;
  logic [23:0] op_addr;
  logic [15:0] op_wdata, rdata;
  logic        txn_in_progress, full, overflow;

  int errors = 0;
  int checks = 0;

  logic [62:0] obs_all;
  logic [62:0] rst_exp;
  logic [23:0] exp_addr [5];
  logic [15:0] exp_wd [5];

  pi_txn_queue #(.DEPTH(4)) dut (
    .c200m(clk), .reset(reset), .wr_stb(wr_stb), .wr_reg(wr_reg), .wr_data(wr_data),
    .op_req(op_req), .op_rw(op_rw), .op_uds_n(op_uds_n), .op_lds_n(op_lds_n),
    .op_addr(op_addr), .op_wdata(op_wdata), .op_ack(op_ack), .op_done(op_done),
    .op_rdata(op_rdata), .rdata(rdata), .txn_in_progress(txn_in_progress),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign obs_all = {op_req, op_rw, op_uds_n, op_lds_n, op_addr, op_wdata, rdata,
                    txn_in_progress, full, overflow};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    wr_stb = 1'b1; wr_reg = r; wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic push(input logic [15:0] data, input logic [15:0] lo, input logic [15:0] hi);
    wr(2'd0, data);
    wr(2'd1, lo);
    wr(2'd2, hi);
  endtask

  task automatic ack_pulse();
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
  endtask

  task automatic done_pulse(input logic [15:0] rd);
    op_done = 1'b1; op_rdata = rd;
    tick();
    op_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (obs_all !== rst_exp) begin errors++; $display("FAIL reset_outputs: got %h exp %h", obs_all, rst_exp); end
    reset = 1'b0;
    tick();
    checks++; if (op_req !== 1'b0) begin errors++; $display("FAIL reset_req_idle: got %b exp 0", op_req); end
  endtask

  task automatic test_word_write();
    push(16'hBEEF, 16'h1234, 16'h0056);
    checks++; if (op_req !== 1'b1) begin errors++; $display("FAIL word_req: got %b exp 1", op_req); end
    checks++; if ({op_addr, op_rw, op_uds_n, op_lds_n, op_wdata} !== {24'h561234, 3'b000, 16'hBEEF}) begin
      errors++; $display("FAIL word_fields: got addr %h rw %b uds %b lds %b wd %h exp 561234 0 0 0 beef",
                         op_addr, op_rw, op_uds_n, op_lds_n, op_wdata); end
    checks++; if (txn_in_progress !== 1'b1) begin errors++; $display("FAIL word_txn_rise: got %b exp 1", txn_in_progress); end
    ack_pulse();
    checks++; if ({op_req, op_addr} !== {1'b0, 24'h561234}) begin errors++; $display("FAIL word_busy_hold: got req %b addr %h exp 0 561234", op_req, op_addr); end
    tick();
    done_pulse(16'h7777);
    checks++; if ({txn_in_progress, op_req, rdata} !== {2'b00, 16'h0000}) begin
      errors++; $display("FAIL word_done: got txn %b req %b rdata %h exp 0 0 0000", txn_in_progress, op_req, rdata); end
  endtask

  task automatic test_byte_read();
    wr(2'd1, 16'h0001);
    wr(2'd2, 16'h0300);
    checks++; if ({op_req, op_rw, op_uds_n, op_lds_n, op_addr} !== {4'b1110, 24'h000001}) begin
      errors++; $display("FAIL byte_fields: got req %b rw %b uds %b lds %b addr %h exp 1 1 1 0 000001",
                         op_req, op_rw, op_uds_n, op_lds_n, op_addr); end
    ack_pulse();
    tick();
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL byte_rdata_early: got %h exp 0000", rdata); end
    done_pulse(16'h00A5);
    checks++; if (rdata !== 16'h00A5) begin errors++; $display("FAIL byte_rdata: got %h exp 00a5", rdata); end
    checks++; if (txn_in_progress !== 1'b0) begin errors++; $display("FAIL byte_txn_fall: got %b exp 0", txn_in_progress); end
    wr(2'd1, 16'h0010);
    wr(2'd2, 16'h0100);
    checks++; if ({op_rw, op_uds_n, op_lds_n} !== 3'b001) begin
      errors++; $display("FAIL byte_even_strobes: got rw %b uds %b lds %b exp 0 0 1", op_rw, op_uds_n, op_lds_n); end
    ack_pulse();
    done_pulse(16'h0000);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = {8'h20 + 8'(i), 16'h1000 + 16'(i)};
      exp_wd[i]   = 16'hD000 + 16'(i);
      push(exp_wd[i], exp_addr[i][15:0], {8'h00, exp_addr[i][23:16]});
      if (i == 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_not_full_at3: got %b exp 0", full); end
      end
    end
    checks++; if ({full, overflow} !== 2'b10) begin errors++; $display("FAIL fill_full: got full %b ovf %b exp 1 0", full, overflow); end
    checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", dut.count_q); end
    push(16'h9999, 16'h9999, 16'h0099);
    checks++; if ({full, overflow} !== 2'b11) begin errors++; $display("FAIL fill_overflow: got full %b ovf %b exp 1 1", full, overflow); end
    checks++; if ({op_addr, op_wdata} !== {exp_addr[0], exp_wd[0]}) begin
      errors++; $display("FAIL fill_head_kept: got %h %h exp %h %h", op_addr, op_wdata, exp_addr[0], exp_wd[0]); end
    wr(2'd3, 16'h0000);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL status_noclear: got %b exp 1", overflow); end
    wr(2'd3, 16'h8000);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL status_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_push_on_ack_full();
    exp_addr[4] = 24'h774444;
    exp_wd[4]   = 16'h4444;
    wr(2'd0, 16'h4444);
    wr(2'd1, 16'h4444);
    wr_stb = 1'b1; wr_reg = 2'd2; wr_data = 16'h0077; op_ack = 1'b1;
    tick();
    wr_stb = 1'b0; op_ack = 1'b0;
    checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL pushack_count: got %0d exp 4", dut.count_q); end
    checks++; if ({full, overflow, op_req} !== 3'b100) begin
      errors++; $display("FAIL pushack_flags: got full %b ovf %b req %b exp 1 0 0", full, overflow, op_req); end
    checks++; if (op_addr !== exp_addr[0]) begin errors++; $display("FAIL pushack_inflight: got %h exp %h", op_addr, exp_addr[0]); end
    for (int k = 1; k < 5; k++) begin
      done_pulse(16'h0000);
      checks++; if ({op_req, op_addr, op_wdata} !== {1'b1, exp_addr[k], exp_wd[k]}) begin
        errors++; $display("FAIL drain_order_%0d: got req %b addr %h wd %h exp 1 %h %h", k, op_req, op_addr, op_wdata, exp_addr[k], exp_wd[k]); end
      ack_pulse();
      checks++; if (op_req !== 1'b0) begin errors++; $display("FAIL drain_req_drop_%0d: got %b exp 0", k, op_req); end
    end
    done_pulse(16'h0000);
    checks++; if ({txn_in_progress, full, op_req, rdata} !== {3'b000, 16'h00A5}) begin
      errors++; $display("FAIL drain_end: got txn %b full %b req %b rdata %h exp 0 0 0 00a5", txn_in_progress, full, op_req, rdata); end
    checks++; if (op_addr !== 24'h774444) begin errors++; $display("FAIL empty_hold: got %h exp 774444", op_addr); end
  endtask

  task automatic test_reset_busy();
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0200);
    ack_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (obs_all !== rst_exp) begin errors++; $display("FAIL rstbusy_outputs: got %h exp %h", obs_all, rst_exp); end
    done_pulse(16'h1111);
    checks++; if ({rdata, op_req, txn_in_progress} !== {16'h0000, 2'b00}) begin
      errors++; $display("FAIL rstbusy_late_done: got rdata %h req %b txn %b exp 0000 0 0", rdata, op_req, txn_in_progress); end
    wr(2'd2, 16'h0042);
    checks++; if ({op_req, op_addr, op_wdata} !== {1'b1, 24'h420000, 16'h0000}) begin
      errors++; $display("FAIL rstbusy_staging: got req %b addr %h wd %h exp 1 420000 0000", op_req, op_addr, op_wdata); end
    ack_pulse();
    done_pulse(16'h0000);
  endtask

  task automatic test_spurious();
    done_pulse(16'h2222);
    checks++; if ({rdata, op_req, txn_in_progress} !== {16'h0000, 2'b00}) begin
      errors++; $display("FAIL idle_done: got rdata %h req %b txn %b exp 0000 0 0", rdata, op_req, txn_in_progress); end
    ack_pulse();
    checks++; if ({op_req, txn_in_progress, op_addr} !== {2'b00, 24'h420000}) begin
      errors++; $display("FAIL empty_ack: got req %b txn %b addr %h exp 0 0 420000", op_req, txn_in_progress, op_addr); end
    push(16'h0A0A, 16'h0A0A, 16'h000A);
    checks++; if ({op_req, op_addr} !== {1'b1, 24'h0A0A0A}) begin
      errors++; $display("FAIL spur_first: got req %b addr %h exp 1 0a0a0a", op_req, op_addr); end
    push(16'h0B0B, 16'h0B0B, 16'h000B);
    ack_pulse();
    op_ack = 1'b1; op_done = 1'b1;
    tick();
    op_ack = 1'b0; op_done = 1'b0;
    checks++; if ({op_req, op_addr, txn_in_progress} !== {1'b1, 24'h0B0B0B, 1'b1}) begin
      errors++; $display("FAIL ack_done_same: got req %b addr %h txn %b exp 1 0b0b0b 1", op_req, op_addr, txn_in_progress); end
    ack_pulse();
    done_pulse(16'h0000);
    checks++; if ({txn_in_progress, op_req} !== 2'b00) begin
      errors++; $display("FAIL spur_drain: got txn %b req %b exp 0 0", txn_in_progress, op_req); end
  endtask

  initial begin
    rst_exp = {1'b0, 1'b1, 1'b1, 1'b1, 24'h0, 16'h0, 16'h0, 3'b000};
    test_reset();
    test_word_write();
    test_byte_read();
    test_fill();
    test_push_on_ack_full();
    test_reset_busy();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
